// File: rtl/button_event_if.sv
// rtl/button_event_if.sv - level input and event output bundle of the button event decoder
interface button_event_if #(
    parameter int N = 1
);
    logic [N-1:0] level_in;
    logic [N-1:0] held;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_pulse;
    logic [N-1:0] repeat_pulse;
    logic         event_any;

    modport master (
        output level_in,
        input  held,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  event_any
    );

    modport slave (
        input  level_in,
        output held,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output repeat_pulse,
        output event_any
    );
endinterface

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - per-channel press/release/long/repeat event decoder
module button_event_decoder #(
    parameter int N            = 1,
    parameter int LONG_TICKS   = 8,
    parameter int REPEAT_TICKS = 4,
    parameter int REPEAT_EN    = 1
) (
    input  logic            clk,
    input  logic            rst,
    button_event_if.slave   bus
);
    localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS) + 1;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Reject timer settings that would make long/repeat timing meaningless
    if (LONG_TICKS < 2) begin : g_bad_long
        $error("button_event_decoder: LONG_TICKS must be >= 2");
    end
    if (REPEAT_TICKS < 1) begin : g_bad_repeat
        $error("button_event_decoder: REPEAT_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    state_t           state    [N];
    state_t           state_nx [N];
    logic [CNT_W-1:0] cnt      [N];
    logic [CNT_W-1:0] cnt_nx   [N];
    logic [N-1:0]     press_nx;
    logic [N-1:0]     release_nx;
    logic [N-1:0]     long_nx;
    logic [N-1:0]     repeat_nx;

    // Next-state and event decode per channel; release always beats timer expiry
    always_comb begin
        press_nx   = '0;
        release_nx = '0;
        long_nx    = '0;
        repeat_nx  = '0;
        for (int i = 0; i < N; i++) begin
            state_nx[i] = state[i];
            cnt_nx[i]   = cnt[i];
            case (state[i])
                IDLE: begin
                    if (bus.level_in[i]) begin
                        press_nx[i] = 1'b1;
                        cnt_nx[i]   = '0;
                        state_nx[i] = PRESSED;
                    end
                end
                PRESSED: begin
                    if (!bus.level_in[i]) begin
                        release_nx[i] = 1'b1;
                        cnt_nx[i]     = '0;
                        state_nx[i]   = IDLE;
                    end else if (cnt[i] == LONG_LAST) begin
                        long_nx[i]  = 1'b1;
                        cnt_nx[i]   = '0;
                        state_nx[i] = HELD;
                    end else begin
                        cnt_nx[i] = cnt[i] + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!bus.level_in[i]) begin
                        release_nx[i] = 1'b1;
                        cnt_nx[i]     = '0;
                        state_nx[i]   = IDLE;
                    end else if (REPEAT_EN != 0) begin
                        if (cnt[i] == REPEAT_LAST) begin
                            repeat_nx[i] = 1'b1;
                            cnt_nx[i]    = '0;
                        end else begin
                            cnt_nx[i] = cnt[i] + CNT_ONE;
                        end
                    end else begin
                        cnt_nx[i] = '0;
                    end
                end
                default: begin
                    cnt_nx[i]   = '0;
                    state_nx[i] = IDLE;
                end
            endcase
        end
    end

    // Channel state, counters and all registered outputs; reset drops any hold silently
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            bus.held          <= '0;
            bus.press_pulse   <= '0;
            bus.release_pulse <= '0;
            bus.long_pulse    <= '0;
            bus.repeat_pulse  <= '0;
            bus.event_any     <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state[i] <= state_nx[i];
                cnt[i]   <= cnt_nx[i];
            end
            bus.held          <= bus.level_in;
            bus.press_pulse   <= press_nx;
            bus.release_pulse <= release_nx;
            bus.long_pulse    <= long_nx;
            bus.repeat_pulse  <= repeat_nx;
            bus.event_any     <= |{press_nx, release_nx, long_nx, repeat_nx};
        end
    end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - randomized and directed bench with a hold-length reference model
module tb_button_event_decoder;
    localparam int LONG_T = 8;
    localparam int REP_T  = 4;

    logic       clk;
    logic       rst;
    logic [1:0] lv;

    int tests = 0;
    int fails = 0;

    button_event_if #(.N(2)) bus0 ();
    button_event_if #(.N(2)) bus1 ();

    assign bus0.level_in = lv;
    assign bus1.level_in = lv;

    button_event_decoder #(
        .N(2), .LONG_TICKS(LONG_T), .REPEAT_TICKS(REP_T), .REPEAT_EN(1)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    button_event_decoder #(
        .N(2), .LONG_TICKS(LONG_T), .REPEAT_TICKS(REP_T), .REPEAT_EN(0)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int d, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %b expected %b at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each channel's length of consecutive pressed samples decides its events
    int         hl   [2][2];
    logic [1:0] e_held [2];
    logic [1:0] e_pr   [2];
    logic [1:0] e_rl   [2];
    logic [1:0] e_lg   [2];
    logic [1:0] e_rp   [2];
    logic       e_any  [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            e_held[d] = '0; e_pr[d] = '0; e_rl[d] = '0; e_lg[d] = '0; e_rp[d] = '0; e_any[d] = 1'b0;
            for (int c = 0; c < 2; c++) hl[d][c] = 0;
        end
        forever begin
            @(posedge clk or negedge rst);
            for (int d = 0; d < 2; d++) begin
                e_pr[d] = '0; e_rl[d] = '0; e_lg[d] = '0; e_rp[d] = '0;
                if (!rst) begin
                    e_held[d] = '0;
                    for (int c = 0; c < 2; c++) hl[d][c] = 0;
                end else begin
                    e_held[d] = lv;
                    for (int c = 0; c < 2; c++) begin
                        if (lv[c]) begin
                            hl[d][c] = hl[d][c] + 1;
                            if (hl[d][c] == 1)
                                e_pr[d][c] = 1'b1;
                            else if (hl[d][c] == LONG_T + 1)
                                e_lg[d][c] = 1'b1;
                            else if (d == 0 && hl[d][c] > LONG_T + 1 && ((hl[d][c] - LONG_T - 1) % REP_T) == 0)
                                e_rp[d][c] = 1'b1;
                        end else begin
                            if (hl[d][c] > 0) e_rl[d][c] = 1'b1;
                            hl[d][c] = 0;
                        end
                    end
                end
                e_any[d] = |{e_pr[d], e_rl[d], e_lg[d], e_rp[d]};
            end
        end
    end

    // Compare both decoders against the model every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            cmp("held",    0, bus0.held,          e_held[0]);
            cmp("press",   0, bus0.press_pulse,   e_pr[0]);
            cmp("release", 0, bus0.release_pulse, e_rl[0]);
            cmp("long",    0, bus0.long_pulse,    e_lg[0]);
            cmp("repeat",  0, bus0.repeat_pulse,  e_rp[0]);
            cmp("any",     0, {1'b0, bus0.event_any}, {1'b0, e_any[0]});
            cmp("held",    1, bus1.held,          e_held[1]);
            cmp("press",   1, bus1.press_pulse,   e_pr[1]);
            cmp("release", 1, bus1.release_pulse, e_rl[1]);
            cmp("long",    1, bus1.long_pulse,    e_lg[1]);
            cmp("repeat",  1, bus1.repeat_pulse,  e_rp[1]);
            cmp("any",     1, {1'b0, bus1.event_any}, {1'b0, e_any[1]});
        end
    end

    // Directed scenarios with literal expectations, then randomized level runs
    initial begin
        int longs;
        int reps;
        int rem [2];

        rst = 1'b0;
        lv  = 2'b00;
        repeat (3) cycle();
        cmp("rst_held", 0, bus0.held, 2'b00);
        cmp("rst_any",  0, {1'b0, bus0.event_any}, 2'b00);
        rst = 1'b1;

        // Idle with both levels low
        for (int k = 0; k < 20; k++) begin
            cycle();
            cmp("idle_any", 0, {1'b0, bus0.event_any}, 2'b00);
        end

        // Three-cycle press: press after e0, release after e3
        lv = 2'b01;
        cycle();
        cmp("short_press", 0, bus0.press_pulse, 2'b01);
        cycle();
        cycle();
        lv = 2'b00;
        cycle();
        cmp("short_release", 0, bus0.release_pulse, 2'b01);
        cmp("short_nolong",  0, bus0.long_pulse, 2'b00);
        cycle();

        // Long hold: long at e8, repeats at e12/e16/e20
        lv = 2'b01;
        reps = 0;
        for (int k = 0; k <= 20; k++) begin
            cycle();
            cmp("hold_held", 0, bus0.held, 2'b01);
            if (k == 0)  cmp("hold_press", 0, bus0.press_pulse, 2'b01);
            if (k == 8)  cmp("hold_long",  0, bus0.long_pulse,  2'b01);
            if (k == 7)  cmp("hold_early", 0, bus0.long_pulse,  2'b00);
            if (k >= 12 && ((k - 12) % 4) == 0) cmp("hold_repeat", 0, bus0.repeat_pulse, 2'b01);
            if (bus0.repeat_pulse[0]) reps++;
        end
        cmp_int("hold_repeat_count", reps, 3);
        lv = 2'b00;
        cycle();
        cmp("hold_release", 0, bus0.release_pulse, 2'b01);
        cycle();

        // Release races the long timer at e8
        lv = 2'b01;
        cycle();
        repeat (7) cycle();
        lv = 2'b00;
        cycle();
        cmp("race_release", 0, bus0.release_pulse, 2'b01);
        cmp("race_nolong",  0, bus0.long_pulse,    2'b00);
        cycle();

        // Two channels staggered by two cycles
        lv = 2'b01;
        cycle();
        cycle();
        lv = 2'b11;
        cycle();
        cmp("stag_press1", 0, bus0.press_pulse, 2'b10);
        for (int k = 3; k <= 15; k++) begin
            cycle();
            if (k == 8)  cmp("stag_long0", 0, bus0.long_pulse,   2'b01);
            if (k == 10) cmp("stag_long1", 0, bus0.long_pulse,   2'b10);
            if (k == 12) cmp("stag_rep0",  0, bus0.repeat_pulse, 2'b01);
            if (k == 14) cmp("stag_rep1",  0, bus0.repeat_pulse, 2'b10);
            if (k == 10) cmp("stag_any",   0, {1'b0, bus0.event_any}, 2'b01);
        end
        lv = 2'b00;
        cycle();
        cmp("stag_release", 0, bus0.release_pulse, 2'b11);
        cycle();

        // Repeat disabled: exactly one long pulse over 20 held cycles
        lv = 2'b01;
        longs = 0;
        reps  = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (bus1.long_pulse[0])   longs++;
            if (bus1.repeat_pulse[0]) reps++;
        end
        cmp_int("norep_long_count",   longs, 1);
        cmp_int("norep_repeat_count", reps,  0);
        lv = 2'b00;
        cycle();
        cycle();

        // Reset in the middle of a hold clears outputs at once
        lv = 2'b01;
        repeat (10) cycle();
        #1;
        rst = 1'b0;
        #1;
        cmp("async_held0", 0, bus0.held, 2'b00);
        cmp("async_held1", 1, bus1.held, 2'b00);
        cmp("async_any",   0, {1'b0, bus0.event_any}, 2'b00);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        cmp("rst_level_press",  0, bus0.press_pulse,   2'b01);
        cmp("rst_no_release",   0, bus0.release_pulse, 2'b00);
        cycle();
        lv = 2'b00;
        cycle();
        cmp("post_release", 0, bus0.release_pulse, 2'b01);
        cycle();

        // Randomized runs of pressed/released levels per channel
        rem[0] = 1;
        rem[1] = 1;
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < 2; c++) begin
                rem[c] = rem[c] - 1;
                if (rem[c] <= 0) begin
                    lv[c]  = ~lv[c];
                    rem[c] = int'($urandom_range(1, 24));
                end
            end
            cycle();
        end
        lv = 2'b00;
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
